cr_osf_debug_ctl_mc: RTL and testbench
======================================

// Module: cr_osf_debug_ctl_mc
// PURPOSE
//  Multi-channel OSF output-FIFO debug controller: per channel, gates HW read/write strobes and masks FIFO empty
//  per a 2-bit debug mode (NORMAL/BLK_RDWR/BLK_RD/SS). Adds registered mode FSM, counted single-step credits,
//  guarded reads, and stall-cycle statistics. Sits between OSF FIFOs and the output-buffer read arbiter.
// PARAMETERS
//  N_CH    4   number of independent FIFO channels
//  STEP_W  8   width of step count / per-channel step credit counter
//  CNT_W   16  width of per-channel saturating blocked-cycle counter
//  RDCNT_W 16  width of breakpoint read counter / compare value (OSF_DEBUG_BRKPT_EN only)
// PORTS
//  clk             in   1             single clock
//  rst_n           in   1             reset, asynchronous, active-low
//  fifo_debug_mode in   2*N_CH        per-ch mode: 0 NORMAL, 1 BLK_RDWR, 2 BLK_RD, 3 SS (ch i at [2i+1:2i])
//  single_step_rd  in   N_CH          per-ch 1-cycle pulse: grant step_cnt read credits
//  step_cnt        in   STEP_W        credits per pulse, shared; 0 treated as 1
//  stat_clr        in   1             pulse: clear all blk_cycles counters
//  fifo_empty      in   N_CH          raw FIFO empty
//  fifo_full       in   N_CH          raw FIFO full
//  ob_rd_ok        in   N_CH          downstream read request
//  src_empty       in   N_CH          upstream source has no data
//  fifo_hw_rd      out  N_CH          FIFO pop strobe
//  fifo_hw_wr      out  N_CH          FIFO push strobe
//  fifo_empty_mod  out  N_CH          empty as seen by downstream
//  step_credit     out  N_CH*STEP_W   current credits (status)
//  blk_cycles      out  N_CH*CNT_W    cycles data held back by debug masking (status)
//  brk_cnt_cfg     in   RDCNT_W       breakpoint read count; 0 = disabled
//  brk_clr         in   N_CH          pulse: clear breakpoint hit and read count
//  brk_hit         out  N_CH          sticky breakpoint hit
// BEHAVIOUR
//  - en_q: 0 in reset, 1 from first clk edge after release. en_q=0: hw_rd=0, hw_wr=0, empty_mod=1 on all ch.
//  - Reset: mode_q=NORMAL, state=RUN, step_credit=0, blk_cycles=0, rd count=0, brk_hit=0.
//  - mode_q registers fifo_debug_mode each cycle: mode change affects outputs 1 cycle later. FSM per ch:
//    RUN (NORMAL), HOLD_RW (BLK_RDWR), HOLD_R (BLK_RD), STEP (SS); next state = f(mode_q) every cycle.
//  - Outputs combinational from state + live inputs (0-cycle latency on fifo_empty/ob_rd_ok/src_empty/full):
//    RUN:     empty_mod=fifo_empty;                 wr=!src_empty&&!fifo_full
//    HOLD_RW: empty_mod=1;                          wr=0
//    HOLD_R:  empty_mod=1;                          wr=!src_empty&&!fifo_full
//    STEP:    empty_mod=fifo_empty||(credit==0);    wr=!src_empty&&!fifo_full
//    all:     hw_rd=ob_rd_ok&&!empty_mod (rd never issued to empty/masked FIFO)
//  - Credit (STEP only): next = sat(credit + (pulse ? max(step_cnt,1) : 0) - hw_rd), saturate at 2^STEP_W-1,
//    never below 0; pulse+read same cycle nets correctly (e.g. 1 + 3 - 1 = 3). Pulses outside STEP ignored.
//    Leaving STEP clears credit to 0 next cycle.
//  - blk_cycles[i] +1 per cycle with !fifo_empty && empty_mod && en_q; saturates at all-ones.
//    stat_clr wins over increment (value 0 next cycle).
//  - Channels fully independent; no cross-channel arbitration.
//  - rst_n assert mid-operation: all state cleared asynchronously; outputs forced per en_q=0 immediately.
// CONFIGURATION
//  OSF_DEBUG_BRKPT_EN defined: per-ch read counter counts hw_rd in RUN; when brk_cnt_cfg!=0 and count reaches
//    brk_cnt_cfg, brk_hit sets (sticky) and ch forced to HOLD_R from next cycle regardless of mode_q,
//    so exactly brk_cnt_cfg reads pass. brk_clr clears hit and count; brk_clr wins over same-cycle hit.
//  Undefined: no counter; brk_hit tied 0; brk_cnt_cfg, brk_clr ignored. Port list identical both ways.
// TESTING
//  1 NORMAL, ch0 empty=0, ob_rd_ok=1, src_empty=0, full=0 -> hw_rd=1, hw_wr=1, empty_mod=0 every cycle.
//  2 mode 0->1 at cycle T, ob_rd_ok=1 -> hw_rd=1 at T, 0 from T+1; hw_wr=0 from T+1; blk_cycles counts +1/cycle.
//  3 SS, step_cnt=3, one pulse, ob_rd_ok=1, FIFO non-empty -> exactly 3 hw_rd, then empty_mod=1, credit=0.
//  4 SS, credit=1, pulse with step_cnt=0 same cycle as read -> credit stays 1; step_cnt=255 at credit 255 -> 255.
//  5 blk_cycles at 16'hFFFF, still blocked -> stays FFFF; stat_clr -> 0 next cycle.
//  6 (BRKPT_EN) brk_cnt_cfg=5, NORMAL streaming -> 5 hw_rd, brk_hit=1, empty_mod=1; brk_clr -> resumes.

Source files
------------

// File: rtl/cr_osf_debug_ctl_mc.sv
// rtl/cr_osf_debug_ctl_mc.sv - per-channel OSF FIFO debug gating: mode FSM, step credits, stall counters
// Optional read-count breakpoint enabled by defining OSF_DEBUG_BRKPT_EN.
module cr_osf_debug_ctl_mc #(
    parameter int N_CH    = 4,
    parameter int STEP_W  = 8,
    parameter int CNT_W   = 16,
    parameter int RDCNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2*N_CH-1:0]       i_fifo_debug_mode,
    input  logic [N_CH-1:0]         i_single_step_rd,
    input  logic [STEP_W-1:0]       i_step_cnt,
    input  logic                    i_stat_clr,
    input  logic [N_CH-1:0]         i_fifo_empty,
    input  logic [N_CH-1:0]         i_fifo_full,
    input  logic [N_CH-1:0]         i_ob_rd_ok,
    input  logic [N_CH-1:0]         i_src_empty,
    output logic [N_CH-1:0]         o_fifo_hw_rd,
    output logic [N_CH-1:0]         o_fifo_hw_wr,
    output logic [N_CH-1:0]         o_fifo_empty_mod,
    output logic [N_CH*STEP_W-1:0]  o_step_credit,
    output logic [N_CH*CNT_W-1:0]   o_blk_cycles,
    input  logic [RDCNT_W-1:0]      i_brk_cnt_cfg,
    input  logic [N_CH-1:0]         i_brk_clr,
    output logic [N_CH-1:0]         o_brk_hit
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HOLD_RW = 2'd1,
        ST_HOLD_R  = 2'd2,
        ST_STEP    = 2'd3
    } state_t;

    logic                r_en;
    state_t              r_state     [N_CH];
    state_t              w_state_nxt [N_CH];
    logic [STEP_W-1:0]   r_credit    [N_CH];
    logic [STEP_W-1:0]   w_credit_nxt[N_CH];
    logic [STEP_W-1:0]   w_add       [N_CH];
    logic [STEP_W:0]     w_sum       [N_CH];
    logic [CNT_W-1:0]    r_blk       [N_CH];
    logic [N_CH-1:0]     w_empty_mod;
    logic [N_CH-1:0]     w_hw_rd;
    logic [N_CH-1:0]     w_hw_wr;
    logic [N_CH-1:0]     w_brk_force;

    // Gating outputs; everything is masked until the first edge after reset release.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_empty_mod[i] = 1'b1;
            w_hw_wr[i]     = 1'b0;
            if (r_en) begin
                case (r_state[i])
                    ST_RUN: begin
                        w_empty_mod[i] = i_fifo_empty[i];
                        w_hw_wr[i]     = !i_src_empty[i] && !i_fifo_full[i];
                    end
                    ST_HOLD_RW: begin
                        w_empty_mod[i] = 1'b1;
                        w_hw_wr[i]     = 1'b0;
                    end
                    ST_HOLD_R: begin
                        w_empty_mod[i] = 1'b1;
                        w_hw_wr[i]     = !i_src_empty[i] && !i_fifo_full[i];
                    end
                    default: begin
                        w_empty_mod[i] = i_fifo_empty[i] || (r_credit[i] == '0);
                        w_hw_wr[i]     = !i_src_empty[i] && !i_fifo_full[i];
                    end
                endcase
            end
            w_hw_rd[i] = r_en && i_ob_rd_ok[i] && !w_empty_mod[i];
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_state_nxt[i] = w_brk_force[i] ? ST_HOLD_R : state_t'(i_fifo_debug_mode[2*i +: 2]);
        end
    end

    // Credit arithmetic is one bit wider so pulse+read nets out before saturating.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_add[i] = '0;
            if (i_single_step_rd[i])
                w_add[i] = (i_step_cnt == '0) ? STEP_W'(1) : i_step_cnt;
            w_sum[i] = {1'b0, r_credit[i]} + {1'b0, w_add[i]} - {{STEP_W{1'b0}}, w_hw_rd[i]};
            if (r_state[i] != ST_STEP)
                w_credit_nxt[i] = '0;
            else if (w_sum[i][STEP_W])
                w_credit_nxt[i] = '1;
            else
                w_credit_nxt[i] = w_sum[i][STEP_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                r_state[i]  <= ST_RUN;
                r_credit[i] <= '0;
                r_blk[i]    <= '0;
            end
        end else begin
            r_en <= 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                r_state[i]  <= w_state_nxt[i];
                r_credit[i] <= w_credit_nxt[i];
                if (i_stat_clr)
                    r_blk[i] <= '0;
                else if (!i_fifo_empty[i] && w_empty_mod[i] && r_en && (r_blk[i] != '1))
                    r_blk[i] <= r_blk[i] + CNT_W'(1);
            end
        end
    end

`ifdef OSF_DEBUG_BRKPT_EN
    logic [RDCNT_W-1:0] r_rdcnt [N_CH];
    logic [N_CH-1:0]    r_brk_hit;
    logic [N_CH-1:0]    w_rd_run;
    logic [N_CH-1:0]    w_brk_trig;

    // Trip on the read that brings the count to the limit so the hold starts before another read.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_rd_run[i]   = w_hw_rd[i] && (r_state[i] == ST_RUN);
            w_brk_trig[i] = w_rd_run[i] && (i_brk_cnt_cfg != '0) &&
                            (r_rdcnt[i] == i_brk_cnt_cfg - RDCNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_brk_hit <= '0;
            for (int i = 0; i < N_CH; i++) r_rdcnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (i_brk_clr[i]) begin
                    r_brk_hit[i] <= 1'b0;
                    r_rdcnt[i]   <= '0;
                end else begin
                    if (w_rd_run[i]) r_rdcnt[i] <= r_rdcnt[i] + RDCNT_W'(1);
                    if (w_brk_trig[i]) r_brk_hit[i] <= 1'b1;
                end
            end
        end
    end

    assign w_brk_force = (r_brk_hit | w_brk_trig) & ~i_brk_clr;
    assign o_brk_hit   = r_brk_hit;
`else
    wire w_unused_brk = ^{i_brk_cnt_cfg, i_brk_clr};
    assign w_brk_force = '0;
    assign o_brk_hit   = '0;
`endif

    assign o_fifo_hw_rd     = w_hw_rd;
    assign o_fifo_hw_wr     = w_hw_wr;
    assign o_fifo_empty_mod = w_empty_mod;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            o_step_credit[i*STEP_W +: STEP_W] = r_credit[i];
            o_blk_cycles[i*CNT_W +: CNT_W]    = r_blk[i];
        end
    end

endmodule

// File: tb/tb_cr_osf_debug_ctl_mc.sv
// tb/tb_cr_osf_debug_ctl_mc.sv - directed vectors for cr_osf_debug_ctl_mc
module tb_cr_osf_debug_ctl_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  mode;
    logic [3:0]  pulse;
    logic [7:0]  step_cnt;
    logic        stat_clr;
    logic [3:0]  fe, ff, ob, se;
    logic [3:0]  hw_rd, hw_wr, em;
    logic [31:0] credit;
    logic [63:0] blk;
    logic [15:0] cfg;
    logic [3:0]  bclr, bhit;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cr_osf_debug_ctl_mc dut (
        .clk(clk), .rst_n(rst_n),
        .i_fifo_debug_mode(mode), .i_single_step_rd(pulse), .i_step_cnt(step_cnt),
        .i_stat_clr(stat_clr), .i_fifo_empty(fe), .i_fifo_full(ff), .i_ob_rd_ok(ob),
        .i_src_empty(se), .o_fifo_hw_rd(hw_rd), .o_fifo_hw_wr(hw_wr),
        .o_fifo_empty_mod(em), .o_step_credit(credit), .o_blk_cycles(blk),
        .i_brk_cnt_cfg(cfg), .i_brk_clr(bclr), .o_brk_hit(bhit)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; mode = 8'h00; pulse = 4'h0; step_cnt = 8'd0; stat_clr = 1'b0;
        fe = 4'hE; ff = 4'h0; ob = 4'h1; se = 4'hE; cfg = 16'd0; bclr = 4'h0;
        #2;
        chk("rst_rd", 32'(hw_rd), 32'h0);
        chk("rst_wr", 32'(hw_wr), 32'h0);
        chk("rst_em", 32'(em), 32'hF);
        chk("rst_credit", credit, 32'h0);
        chk("rst_blk0", 32'(blk[15:0]), 32'h0);
        chk("rst_brk", 32'(bhit), 32'h0);
        #6 rst_n = 1'b1;

        tick; #1;
        chk("t1_rd", 32'(hw_rd), 32'h1);
        chk("t1_wr", 32'(hw_wr), 32'h1);
        chk("t1_em", 32'(em), 32'hE);
        tick; #1;
        chk("t1_rd2", 32'(hw_rd), 32'h1);

        tick; mode = 8'h01; #1;
        chk("t2_rd_T", 32'(hw_rd), 32'h1);
        chk("t2_blk_T", 32'(blk[15:0]), 32'h0);
        tick; #1;
        chk("t2_rd_T1", 32'(hw_rd), 32'h0);
        chk("t2_wr_T1", 32'(hw_wr), 32'h0);
        chk("t2_em_T1", 32'(em), 32'hF);
        chk("t2_blk_T1", 32'(blk[15:0]), 32'h0);
        tick; #1;
        chk("t2_blk_T2", 32'(blk[15:0]), 32'h1);
        tick; #1;
        chk("t2_blk_T3", 32'(blk[15:0]), 32'h2);
        mode = 8'h02;
        tick; #1;
        chk("hr_blk", 32'(blk[15:0]), 32'h3);
        chk("hr_wr", 32'(hw_wr), 32'h1);
        chk("hr_rd", 32'(hw_rd), 32'h0);
        chk("hr_em", 32'(em), 32'hF);
        tick; stat_clr = 1'b1; #1;
        chk("clr_blk_pre", 32'(blk[15:0]), 32'h4);
        tick; stat_clr = 1'b0; #1;
        chk("clr_blk", 32'(blk[15:0]), 32'h0);
        tick; #1;
        chk("clr_blk_inc", 32'(blk[15:0]), 32'h1);

        mode = 8'h03;
        tick; #1;
        chk("t3_em0", 32'(em), 32'hF);
        chk("t3_rd0", 32'(hw_rd), 32'h0);
        chk("t3_cr0", credit, 32'h0);
        pulse = 4'h1; step_cnt = 8'd3;
        tick; pulse = 4'h0; #1;
        chk("t3_cr3", credit, 32'd3);
        chk("t3_rd_a", 32'(hw_rd), 32'h1);
        chk("t3_em_a", 32'(em), 32'hE);
        tick; #1;
        chk("t3_cr2", credit, 32'd2);
        chk("t3_rd_b", 32'(hw_rd), 32'h1);
        tick; #1;
        chk("t3_cr1", credit, 32'd1);
        chk("t3_rd_c", 32'(hw_rd), 32'h1);
        tick; #1;
        chk("t3_cr_end", credit, 32'd0);
        chk("t3_rd_end", 32'(hw_rd), 32'h0);
        chk("t3_em_end", 32'(em), 32'hF);

        pulse = 4'h1; step_cnt = 8'd1;
        tick; step_cnt = 8'd0; #1;
        chk("t4_cr1", credit, 32'd1);
        chk("t4_rd", 32'(hw_rd), 32'h1);
        tick; #1;
        chk("t4_net", credit, 32'd1);
        step_cnt = 8'd255; ob = 4'h0;
        tick; ob = 4'h1; #1;
        chk("t4_sat", credit, 32'd255);
        chk("t4_sat_rd", 32'(hw_rd), 32'h1);
        tick; #1;
        chk("t4_sat2", credit, 32'd255);
        pulse = 4'h0; mode = 8'h00;
        tick; pulse = 4'h1; step_cnt = 8'd5; #1;
        chk("lv_cr", credit, 32'd254);
        tick; pulse = 4'h0; #1;
        chk("lv_clr", credit, 32'd0);

        mode = 8'h01; stat_clr = 1'b1;
        tick; stat_clr = 1'b0; fe = 4'hC; se = 4'hC; ob = 4'h3; #1;
        chk("t5_blk0", 32'(blk[15:0]), 32'h0);
        chk("ind_rd", 32'(hw_rd), 32'h2);
        chk("ind_wr", 32'(hw_wr), 32'h2);
        repeat (65534) @(posedge clk);
        #2;
        chk("t5_fffe", 32'(blk[15:0]), 32'hFFFE);
        tick; #1;
        chk("t5_ffff", 32'(blk[15:0]), 32'hFFFF);
        repeat (3) tick;
        #1;
        chk("t5_hold", 32'(blk[15:0]), 32'hFFFF);
        chk("t5_ch1", 32'(blk[31:16]), 32'h0);
        stat_clr = 1'b1;
        tick; stat_clr = 1'b0; #1;
        chk("t5_clr", 32'(blk[15:0]), 32'h0);

        #2 rst_n = 1'b0;
        #1;
        chk("arst_wr", 32'(hw_wr), 32'h0);
        chk("arst_rd", 32'(hw_rd), 32'h0);
        chk("arst_em", 32'(em), 32'hF);
        chk("arst_blk", 32'(blk[15:0]), 32'h0);

        mode = 8'h00; fe = 4'hE; se = 4'hE; ob = 4'h1; cfg = 16'd5;
        #2 rst_n = 1'b1;
        tick;
`ifdef OSF_DEBUG_BRKPT_EN
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t6_rd", 32'(hw_rd), 32'h1);
            chk("t6_hit0", 32'(bhit), 32'h0);
            tick;
        end
        #1;
        chk("t6_stop_rd", 32'(hw_rd), 32'h0);
        chk("t6_hit", 32'(bhit), 32'h1);
        chk("t6_em", 32'(em), 32'hF);
        bclr = 4'h1;
        tick; bclr = 4'h0; #1;
        chk("t6_clr_hit", 32'(bhit), 32'h0);
        chk("t6_resume", 32'(hw_rd), 32'h1);
`else
        for (int k = 0; k < 7; k++) begin
            #1;
            chk("nobrk_rd", 32'(hw_rd), 32'h1);
            chk("nobrk_hit", 32'(bhit), 32'h0);
            tick;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
